// File: rtl/instr_fetch.sv
// instr_fetch: sequential instruction fetch unit with a 2-entry {pc, instr} output FIFO.
//
// Each cycle the unit fetches the word at pc. The fetch is pushed into the FIFO
// when there is room, or when the head entry is leaving in the same cycle.
// A redirect flushes the FIFO and restarts fetch at the word-aligned target.
// While the FIFO is full and nothing is popped, pc holds.
//
// Optional feature: define FETCH_PERF_EN to add f_count, a 32-bit count of
// accepted (popped) entries.
//
// Ports:
//   clk            clock; all state changes on the rising edge
//   rst            asynchronous active-high reset
//   imem_addr      word index into instruction memory, pc[IMEM_AW+1:2]
//   imem_rdata     instruction for imem_addr, returned in the same cycle
//   redirect_valid branch/jump redirect request; has priority over everything else
//   redirect_pc    redirect target byte address; bits [1:0] are ignored
//   f_valid        head entry is available to decode
//   f_ready        decode accepts the head entry
//   f_instr        instruction of the head entry
//   f_pc           byte address of the head entry
//   f_count        (FETCH_PERF_EN only) number of accepted entries, wraps at 2^32
module instr_fetch #(
  parameter int unsigned IMEM_AW  = 8,
  parameter int unsigned ILEN     = 32,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic               clk,
  input  logic               rst,
  output logic [IMEM_AW-1:0] imem_addr,
  input  logic [ILEN-1:0]    imem_rdata,
  input  logic               redirect_valid,
  input  logic [31:0]        redirect_pc,
`ifdef FETCH_PERF_EN
  output logic [31:0]        f_count,
`endif
  output logic               f_valid,
  input  logic               f_ready,
  output logic [ILEN-1:0]    f_instr,
  output logic [31:0]        f_pc
);

  logic [31:0]     pc_q;
  logic [31:0]     fifo_pc_q    [2];
  logic [ILEN-1:0] fifo_instr_q [2];
  logic            wr_ptr_q;
  logic            rd_ptr_q;
  logic [1:0]      count_q;

  logic pop;
  logic push;

  // Only the word part of the redirect target matters.
  logic unused_redirect_lsb;
  assign unused_redirect_lsb = ^redirect_pc[1:0];

  always_comb begin
    pop  = f_valid & f_ready & ~redirect_valid;
    // A pop in the same cycle frees the slot this push will occupy.
    push = ~redirect_valid & ((count_q < 2'd2) | pop);
  end

  assign imem_addr = pc_q[IMEM_AW+1:2];
  assign f_valid   = (count_q != 2'd0);
  assign f_pc      = fifo_pc_q[rd_ptr_q];
  assign f_instr   = fifo_instr_q[rd_ptr_q];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q            <= RESET_PC;
      wr_ptr_q        <= 1'b0;
      rd_ptr_q        <= 1'b0;
      count_q         <= 2'd0;
      fifo_pc_q[0]    <= 32'd0;
      fifo_pc_q[1]    <= 32'd0;
      fifo_instr_q[0] <= '0;
      fifo_instr_q[1] <= '0;
    end else if (redirect_valid) begin
      // Flush: any head entry shown this cycle is dropped, not handed over.
      pc_q     <= {redirect_pc[31:2], 2'b00};
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push) begin
        fifo_pc_q[wr_ptr_q]    <= pc_q;
        fifo_instr_q[wr_ptr_q] <= imem_rdata;
        wr_ptr_q               <= ~wr_ptr_q;
        pc_q                   <= pc_q + 32'd4;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      if (push && !pop) begin
        count_q <= count_q + 2'd1;
      end else if (pop && !push) begin
        count_q <= count_q - 2'd1;
      end
    end
  end

`ifdef FETCH_PERF_EN
  logic [31:0] f_count_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      f_count_q <= 32'd0;
    end else if (pop) begin
      f_count_q <= f_count_q + 32'd1;
    end
  end

  assign f_count = f_count_q;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: directed and randomized checks of instr_fetch against a
// queue-based reference model. Build with +define+FETCH_PERF_EN to also check f_count.
module tb_instr_fetch;

  localparam int unsigned IMEM_AW  = 8;
  localparam int unsigned ILEN     = 32;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic               clk;
  logic               rst;
  logic [IMEM_AW-1:0] imem_addr;
  logic [ILEN-1:0]    imem_rdata;
  logic               redirect_valid;
  logic [31:0]        redirect_pc;
  logic               f_valid;
  logic               f_ready;
  logic [ILEN-1:0]    f_instr;
  logic [31:0]        f_pc;
`ifdef FETCH_PERF_EN
  logic [31:0]        f_count;
`endif

  logic [31:0] mem [2**IMEM_AW];
  assign imem_rdata = mem[imem_addr];

  instr_fetch #(
    .IMEM_AW (IMEM_AW),
    .ILEN    (ILEN),
    .RESET_PC(RESET_PC)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .imem_addr     (imem_addr),
    .imem_rdata    (imem_rdata),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
`ifdef FETCH_PERF_EN
    .f_count       (f_count),
`endif
    .f_valid       (f_valid),
    .f_ready       (f_ready),
    .f_instr       (f_instr),
    .f_pc          (f_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: the FIFO is just a queue of fetched entries.
  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  ent_t        q[$];
  logic [31:0] m_pc;
  int unsigned m_pops;
  int unsigned checks;
  int unsigned passes;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic check_outputs();
    chk("f_valid", 32'(f_valid), 32'(q.size() != 0));
    chk("imem_addr", 32'(imem_addr), 32'(m_pc[IMEM_AW+1:2]));
    if (q.size() != 0) begin
      chk("f_pc", f_pc, q[0].pc);
      chk("f_instr", f_instr, q[0].instr);
    end
`ifdef FETCH_PERF_EN
    chk("f_count", f_count, m_pops);
`endif
  endtask

  // Called just after a falling edge; returns just after the next falling edge.
  task automatic do_cycle(input logic rv, input logic [31:0] rpc, input logic rdy);
    ent_t e;
    redirect_valid = rv;
    redirect_pc    = rpc;
    f_ready        = rdy;
    #1;
    check_outputs();
    if (rv) begin
      q.delete();
      m_pc = {rpc[31:2], 2'b00};
    end else begin
      if (q.size() != 0 && rdy) begin
        q.delete(0);
        m_pops++;
      end
      if (q.size() < 2) begin
        e.pc    = m_pc;
        e.instr = mem[m_pc[IMEM_AW+1:2]];
        q.push_back(e);
        m_pc = m_pc + 32'd4;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  // Asserts reset between clock edges; outputs must clear with no edge.
  task automatic do_reset();
    rst = 1'b1;
    #1;
    chk("rst_f_valid", 32'(f_valid), 32'd0);
    chk("rst_imem_addr", 32'(imem_addr), 32'(RESET_PC[IMEM_AW+1:2]));
    q.delete();
    m_pc   = RESET_PC;
    m_pops = 0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    checks         = 0;
    passes         = 0;
    m_pops         = 0;
    m_pc           = RESET_PC;
    rst            = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 32'd0;
    f_ready        = 1'b0;
    for (int i = 0; i < 2**IMEM_AW; i++) begin
      mem[i] = (i < 16) ? 32'(i) : $urandom;
    end

    // Reset release, streaming with f_ready high: f_pc 0,4,8,12 / f_instr 0,1,2,3.
    @(negedge clk);
    do_reset();
    for (int i = 0; i < 6; i++) do_cycle(1'b0, 32'd0, 1'b1);

    // Stall from reset: FIFO fills to two, pc holds at 8, then drains without a gap.
    do_reset();
    for (int i = 0; i < 5; i++) do_cycle(1'b0, 32'd0, 1'b0);
    chk("stall_imem_addr", 32'(imem_addr), 32'd2);
    chk("stall_f_pc", f_pc, 32'd0);
    for (int i = 0; i < 4; i++) do_cycle(1'b0, 32'd0, 1'b1);

    // Redirect to 0x40 while full and f_ready high: head dropped, one bubble.
    for (int i = 0; i < 3; i++) do_cycle(1'b0, 32'd0, 1'b0);
    do_cycle(1'b1, 32'h40, 1'b1);
    for (int i = 0; i < 4; i++) do_cycle(1'b0, 32'd0, 1'b1);

    // Unaligned redirect target: fetch at 0x40, word index 0x10.
    do_cycle(1'b1, 32'h43, 1'b1);
    chk("unaligned_imem_addr", 32'(imem_addr), 32'h10);
    for (int i = 0; i < 3; i++) do_cycle(1'b0, 32'd0, 1'b1);

    // Word index wraps past the memory size; pc wraps past 2^32.
    do_cycle(1'b1, 32'h0000_03F8, 1'b1);
    for (int i = 0; i < 4; i++) do_cycle(1'b0, 32'd0, 1'b1);
    do_cycle(1'b1, 32'hFFFF_FFF8, 1'b1);
    for (int i = 0; i < 4; i++) do_cycle(1'b0, 32'd0, 1'b1);

    // Back-to-back redirects: last target wins.
    do_cycle(1'b1, 32'h100, 1'b1);
    do_cycle(1'b1, 32'h200, 1'b1);
    for (int i = 0; i < 3; i++) do_cycle(1'b0, 32'd0, 1'b1);

    // Asynchronous reset mid-stream with the FIFO full.
    for (int i = 0; i < 3; i++) do_cycle(1'b0, 32'd0, 1'b0);
    chk("full_before_rst", 32'(f_valid), 32'd1);
    do_reset();
    for (int i = 0; i < 3; i++) do_cycle(1'b0, 32'd0, 1'b1);

    // Ten accepted entries and one dropped by a redirect.
    do_reset();
    for (int i = 0; i < 11; i++) do_cycle(1'b0, 32'd0, 1'b1);
    do_cycle(1'b1, 32'h80, 1'b1);
    chk("pops_after_drop", 32'(m_pops), 32'd10);
    do_cycle(1'b0, 32'd0, 1'b0);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      do_cycle(($urandom_range(0, 7) == 0), $urandom, 1'($urandom_range(0, 1)));
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule
